// File: rtl/ram_wb_arbiter_pkg.sv
// ram_wb_arb_pkg: shared types and constants for the two-master ram_wb arbiter.
//   arb_state_e : arbiter FSM states (IDLE / OWN0 / OWN1 / GAP)
//   CTI_*       : Wishbone cycle-type codes used on the shared bus
//   SEL_W/CTI_W : fixed byte-select and cycle-type widths
package ram_wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2,
    GAP  = 2'd3
  } arb_state_e;

  localparam int SEL_W = 4;
  localparam int CTI_W = 3;

  localparam logic [CTI_W-1:0] CTI_CLASSIC = 3'b000;
  localparam logic [CTI_W-1:0] CTI_INCR    = 3'b010;
  localparam logic [CTI_W-1:0] CTI_EOB     = 3'b111;

endpackage

// File: rtl/ram_wb_arbiter_if.sv
// ram_wb_arb_if: one Wishbone link (master <-> slave).
//   master modport : drives cyc/stb/we/sel/adr/dat_w/cti, receives dat_r/ack(/err)
//   slave  modport : the mirror image
// err exists only when RAM_WB_ARB_TIMEOUT_EN is defined.
interface ram_wb_arb_if #(
  parameter int DAT_WIDTH = 32,
  parameter int ADR_WIDTH = 16
);
  import ram_wb_arb_pkg::*;

  logic                 cyc;
  logic                 stb;
  logic                 we;
  logic [SEL_W-1:0]     sel;
  logic [ADR_WIDTH-1:2] adr;
  logic [DAT_WIDTH-1:0] dat_w;
  logic [CTI_W-1:0]     cti;
  logic [DAT_WIDTH-1:0] dat_r;
  logic                 ack;
`ifdef RAM_WB_ARB_TIMEOUT_EN
  logic                 err;
`endif

`ifdef RAM_WB_ARB_TIMEOUT_EN
  modport master (output cyc, stb, we, sel, adr, dat_w, cti, input dat_r, ack, err);
  modport slave  (input cyc, stb, we, sel, adr, dat_w, cti, output dat_r, ack, err);
`else
  modport master (output cyc, stb, we, sel, adr, dat_w, cti, input dat_r, ack);
  modport slave  (input cyc, stb, we, sel, adr, dat_w, cti, output dat_r, ack);
`endif

endinterface

// File: rtl/ram_wb_arbiter_rr.sv
// ram_wb_arb_rr: two-way round-robin pick.
//   req0/req1 : pending requests
//   last      : index of the master served most recently
//   gnt       : chosen master index (valid when any=1)
//   any       : at least one request pending
// On a tie the master that was not served last wins; a lone requester
// always wins regardless of last.
module ram_wb_arb_rr (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic gnt,
  output logic any
);

  assign any = req0 | req1;
  assign gnt = (req0 & req1) ? ~last : req1;

endmodule

// File: rtl/ram_wb_arbiter.sv
// ram_wb_arbiter: two Wishbone masters share one ram_wb slave port.
//   clk_i    : clock, rising edge
//   rst_n_i  : synchronous reset, active low
//   m0, m1   : master links (slave modport), dat_r broadcast, ack to owner only
//   s        : shared slave link (master modport), muxed from the owner
// Grant is round-robin and held for the owner's whole cyc, bursts included.
// A one-cycle GAP follows every ownership so the slave's ack drains before
// the next owner is presented. Nothing in the data path is registered.
// Optional feature macro: RAM_WB_ARB_TIMEOUT_EN -- adds a stall counter that
// aborts an owner stalled for TIMEOUT_CYCLES cycles with a one-cycle err.
module ram_wb_arbiter
  import ram_wb_arb_pkg::*;
#(
  parameter int DAT_WIDTH      = 32,
  parameter int ADR_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic           clk_i,
  input logic           rst_n_i,
  ram_wb_arb_if.slave   m0,
  ram_wb_arb_if.slave   m1,
  ram_wb_arb_if.master  s
);

  arb_state_e state, state_nxt;
  logic       last, last_nxt;
  logic       req0, req1, gnt, any;
  logic       tmo;

  assign req0 = m0.cyc & m0.stb;
  assign req1 = m1.cyc & m1.stb;

  ram_wb_arb_rr u_rr (
    .req0 (req0),
    .req1 (req1),
    .last (last),
    .gnt  (gnt),
    .any  (any)
  );

`ifdef RAM_WB_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt;
  logic             own, own_stb;

  assign own     = (state == OWN0) | (state == OWN1);
  assign own_stb = ((state == OWN0) & m0.stb) | ((state == OWN1) & m1.stb);
  assign tmo     = own & (cnt == CNT_W'(TIMEOUT_CYCLES));

  // Counts stalled strobe cycles of the current owner; any ack or any
  // state change (including the abort itself) starts it over.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i)                           cnt <= '0;
    else if (state_nxt != state || s.ack)   cnt <= '0;
    else if (own_stb)                       cnt <= cnt + 1'b1;
  end
`else
  assign tmo = 1'b0;
`endif

  // Next state / last-served pointer
  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    case (state)
      IDLE: if (any) state_nxt = gnt ? OWN1 : OWN0;
      OWN0: if (!m0.cyc || tmo) begin
        state_nxt = GAP;
        last_nxt  = 1'b0;
      end
      OWN1: if (!m1.cyc || tmo) begin
        state_nxt = GAP;
        last_nxt  = 1'b1;
      end
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // last=1 out of reset so m0 wins the first tie
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
    end
  end

  // Owner decode is qualified by rst_n_i so a reset asserted mid-burst
  // silences the slave and the acks in that same cycle.
  logic own0, own1;
  assign own0 = rst_n_i & (state == OWN0);
  assign own1 = rst_n_i & (state == OWN1);

  logic                 s_cyc, s_stb, s_we;
  logic [SEL_W-1:0]     s_sel;
  logic [ADR_WIDTH-1:2] s_adr;
  logic [DAT_WIDTH-1:0] s_dat;
  logic [CTI_W-1:0]     s_cti;

  always_comb begin
    s_cyc = 1'b0;
    s_stb = 1'b0;
    s_we  = 1'b0;
    s_sel = '0;
    s_adr = '0;
    s_dat = '0;
    s_cti = CTI_CLASSIC;
    if (own0) begin
      s_cyc = m0.cyc & ~tmo;
      s_stb = m0.stb & ~tmo;
      s_we  = m0.we;
      s_sel = m0.sel;
      s_adr = m0.adr;
      s_dat = m0.dat_w;
      s_cti = m0.cti;
    end else if (own1) begin
      s_cyc = m1.cyc & ~tmo;
      s_stb = m1.stb & ~tmo;
      s_we  = m1.we;
      s_sel = m1.sel;
      s_adr = m1.adr;
      s_dat = m1.dat_w;
      s_cti = m1.cti;
    end
  end

  assign s.cyc   = s_cyc;
  assign s.stb   = s_stb;
  assign s.we    = s_we;
  assign s.sel   = s_sel;
  assign s.adr   = s_adr;
  assign s.dat_w = s_dat;
  assign s.cti   = s_cti;

  // An ack that coincides with the owner dropping cyc belongs to no one.
  assign m0.ack   = own0 & m0.cyc & s.ack & ~tmo;
  assign m1.ack   = own1 & m1.cyc & s.ack & ~tmo;
  assign m0.dat_r = s.dat_r;
  assign m1.dat_r = s.dat_r;

`ifdef RAM_WB_ARB_TIMEOUT_EN
  assign m0.err = own0 & tmo;
  assign m1.err = own1 & tmo;
`endif

endmodule

// File: tb/tb_ram_wb_arbiter.sv
// Directed bench for ram_wb_arbiter with a behavioural ram_wb slave
// (ack one cycle after strobe, back-to-back acks for incrementing bursts).
// Read data expectations come from a reference memory and are queued per
// master when a read beat is issued, then popped at that master's ack.
module tb_ram_wb_arbiter;
  import ram_wb_arb_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ram_wb_arb_if #(.DAT_WIDTH(32), .ADR_WIDTH(16)) m0_bus ();
  ram_wb_arb_if #(.DAT_WIDTH(32), .ADR_WIDTH(16)) m1_bus ();
  ram_wb_arb_if #(.DAT_WIDTH(32), .ADR_WIDTH(16)) s_bus ();

  ram_wb_arbiter #(.DAT_WIDTH(32), .ADR_WIDTH(16), .TIMEOUT_CYCLES(8)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .m0      (m0_bus),
    .m1      (m1_bus),
    .s       (s_bus)
  );

  // master drive
  logic        m_cyc [2];
  logic        m_stb [2];
  logic        m_we  [2];
  logic [3:0]  m_sel [2];
  logic [13:0] m_adr [2];
  logic [31:0] m_dat [2];
  logic [2:0]  m_cti [2];

  assign m0_bus.cyc = m_cyc[0]; assign m1_bus.cyc = m_cyc[1];
  assign m0_bus.stb = m_stb[0]; assign m1_bus.stb = m_stb[1];
  assign m0_bus.we  = m_we[0];  assign m1_bus.we  = m_we[1];
  assign m0_bus.sel = m_sel[0]; assign m1_bus.sel = m_sel[1];
  assign m0_bus.adr = m_adr[0]; assign m1_bus.adr = m_adr[1];
  assign m0_bus.dat_w = m_dat[0]; assign m1_bus.dat_w = m_dat[1];
  assign m0_bus.cti = m_cti[0]; assign m1_bus.cti = m_cti[1];
`ifdef RAM_WB_ARB_TIMEOUT_EN
  assign s_bus.err = 1'b0;
`endif

  // ram_wb slave model
  logic [31:0] mem [256];
  logic        ram_ack, ack_off, ram_clr;
  assign s_bus.ack   = ram_ack;
  assign s_bus.dat_r = mem[s_bus.adr[9:2]];

  always @(posedge clk) begin
    if (ram_clr)
      for (int i = 0; i < 256; i++) mem[i] <= 32'hC0DE_0000 | 32'(i);
    if (!rst_n) ram_ack <= 1'b0;
    else begin
      ram_ack <= s_bus.cyc & s_bus.stb & ~ack_off &
                 ~(ram_ack & (s_bus.cti == CTI_CLASSIC || s_bus.cti == CTI_EOB));
      if (s_bus.cyc & s_bus.stb & s_bus.we & ram_ack)
        for (int k = 0; k < 4; k++)
          if (s_bus.sel[k]) mem[s_bus.adr[9:2]][8*k +: 8] <= s_bus.dat_w[8*k +: 8];
    end
  end

  // reference memory + scoreboard
  logic [31:0] ref_mem [256];
  logic [31:0] exp_q0 [$];
  logic [31:0] exp_q1 [$];
  int n_pass = 0, n_fail = 0, n_chk = 0;
  int cyc_cnt = 0;
  int t_done [2];

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic ack_of(input int m);
    return (m == 0) ? m0_bus.ack : m1_bus.ack;
  endfunction

  function automatic logic [31:0] dat_of(input int m);
    return (m == 0) ? m0_bus.dat_r : m1_bus.dat_r;
  endfunction

  task automatic ref_wr(input logic [13:0] a, input logic [31:0] d, input logic [3:0] sel);
    for (int k = 0; k < 4; k++)
      if (sel[k]) ref_mem[a[7:0]][8*k +: 8] = d[8*k +: 8];
  endtask

  // one master transaction: classic if beats==1, else incrementing burst
  task automatic xfer(input int m, input logic we, input logic [13:0] adr,
                      input logic [31:0] dat, input logic [3:0] sel, input int beats,
                      output int lat, output logic [31:0] rdata);
    int          n;
    logic [13:0] a;
    logic [31:0] d, e;
    lat = 0;
    rdata = '0;
    for (int b = 0; b < beats; b++) begin
      a = adr + 14'(b);
      d = dat + 32'(b);
      m_cyc[m] = 1'b1; m_stb[m] = 1'b1; m_we[m] = we; m_sel[m] = sel;
      m_adr[m] = a;    m_dat[m] = d;
      m_cti[m] = (beats == 1) ? CTI_CLASSIC : (b == beats - 1) ? CTI_EOB : CTI_INCR;
      if (we) ref_wr(a, d, sel);
      else if (m == 0) exp_q0.push_back(ref_mem[a[7:0]]);
      else exp_q1.push_back(ref_mem[a[7:0]]);
      n = 0;
      do begin @(negedge clk); n++; end while (!ack_of(m) && n < 40);
      chk($sformatf("ack_seen m%0d", m), 32'(ack_of(m)), 32'd1);
      if (b == 0) lat = n;
      else chk("burst_back_to_back", 32'(n), 32'd1);
      if (!we) begin
        e = 'x;
        if (m == 0 && exp_q0.size() > 0) e = exp_q0.pop_front();
        if (m == 1 && exp_q1.size() > 0) e = exp_q1.pop_front();
        chk($sformatf("rdata m%0d", m), dat_of(m), e);
      end
      rdata = dat_of(m);
      t_done[m] = cyc_cnt;
      @(posedge clk); #1;
    end
    m_cyc[m] = 1'b0; m_stb[m] = 1'b0; m_we[m] = 1'b0; m_cti[m] = CTI_CLASSIC;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  // ack must only ever reach a master that is running a cycle, never both
  always @(negedge clk)
    if (rst_n)
      chk("ack_owner_only",
          32'((m0_bus.ack & ~m_cyc[0]) | (m1_bus.ack & ~m_cyc[1]) | (m0_bus.ack & m1_bus.ack)),
          32'd0);

  initial begin
    int          lat, lat1, n;
    logic [31:0] rd;
    ack_off = 1'b0;
    ram_clr = 1'b1;
    for (int i = 0; i < 2; i++) begin
      m_cyc[i] = 1'b0; m_stb[i] = 1'b0; m_we[i] = 1'b0; m_sel[i] = 4'hF;
      m_adr[i] = '0;   m_dat[i] = '0;   m_cti[i] = CTI_CLASSIC;
    end
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'hC0DE_0000 | 32'(i);

    // 1: reset with both masters requesting, then m0 wins the first tie
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_adr[0] = 14'h1;
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_adr[1] = 14'h2;
    repeat (3) begin
      @(negedge clk);
      chk("rst_s_cyc", 32'(s_bus.cyc), 32'd0);
      chk("rst_s_stb_we", 32'({s_bus.stb, s_bus.we}), 32'd0);
      chk("rst_s_sel_cti", 32'({s_bus.sel, s_bus.cti}), 32'd0);
      chk("rst_acks", 32'({m0_bus.ack, m1_bus.ack}), 32'd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    ram_clr = 1'b0;
    @(negedge clk);
    chk("post_rst_no_grant_yet", 32'(s_bus.cyc), 32'd0);
    @(negedge clk);
    chk("post_rst_m0_granted", 32'({s_bus.cyc, s_bus.stb}), 32'd3);
    chk("post_rst_adr", 32'(s_bus.adr), 32'h1);
    @(negedge clk);
    chk("post_rst_m0_ack", 32'(m0_bus.ack), 32'd1);
    chk("post_rst_m0_data", m0_bus.dat_r, 32'hC0DE_0001);
    chk("post_rst_m1_waits", 32'(m1_bus.ack), 32'd0);
    @(posedge clk); #1;
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!m1_bus.ack && n < 20);
    chk("pending_m1_after_gap", 32'(n), 32'd5);
    chk("pending_m1_data", m1_bus.dat_r, 32'hC0DE_0002);
    @(posedge clk); #1;
    m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
    idle(3);

    // 2: m1 single classic read at 0x10
    fork
      xfer(1, 1'b0, 14'h10, 32'h0, 4'hF, 1, lat, rd);
      begin
        @(negedge clk); @(negedge clk);
        chk("m1_grant_cyc", 32'(s_bus.cyc), 32'd1);
        chk("m1_grant_adr", 32'(s_bus.adr), 32'h10);
      end
    join
    chk("m1_read_latency", 32'(lat), 32'd3);
    idle(3);

    // 3: tie with last=0 -> m1 first, GAP, then m0
    xfer(0, 1'b0, 14'h05, 32'h0, 4'hF, 1, lat, rd);
    idle(3);
    fork
      xfer(0, 1'b0, 14'h06, 32'h0, 4'hF, 1, lat, rd);
      xfer(1, 1'b0, 14'h07, 32'h0, 4'hF, 1, lat1, rd);
    join
    chk("tie_m1_latency", 32'(lat1), 32'd3);
    chk("tie_m0_after_gap", 32'(t_done[0] - t_done[1]), 32'd5);
    idle(3);

    // 4: m0 4-beat burst write while m1 waits, then readback burst
    fork
      xfer(0, 1'b1, 14'h20, 32'hB000_0000, 4'hF, 4, lat, rd);
      begin
        @(posedge clk); #1;
        xfer(1, 1'b0, 14'h08, 32'h0, 4'hF, 1, lat1, rd);
      end
    join
    chk("burst_m1_after_gap", 32'(t_done[1] - t_done[0]), 32'd5);
    idle(3);
    xfer(0, 1'b0, 14'h20, 32'h0, 4'hF, 4, lat, rd);
    chk("burst_read_last", rd, 32'hB000_0003);
    idle(3);

    // 5: partial byte write
    xfer(0, 1'b1, 14'h30, 32'h1122_3344, 4'hF, 1, lat, rd);
    xfer(0, 1'b1, 14'h30, 32'hAABB_CCDD, 4'b0010, 1, lat, rd);
    xfer(1, 1'b0, 14'h30, 32'h0, 4'hF, 1, lat, rd);
    chk("byte_write_merge", rd, 32'h1122_CC44);
    idle(3);

    // reset in the middle of a burst read
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_we[0] = 1'b0; m_adr[0] = 14'h40; m_cti[0] = CTI_INCR;
    @(negedge clk); @(negedge clk); @(negedge clk);
    chk("midburst_first_ack", 32'(m0_bus.ack), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    m_adr[0] = 14'h41;
    @(negedge clk);
    chk("midburst_rst_s_cyc_stb", 32'({s_bus.cyc, s_bus.stb}), 32'd0);
    chk("midburst_rst_no_ack", 32'(m0_bus.ack), 32'd0);
    @(posedge clk); #1;
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0; m_cti[0] = CTI_CLASSIC;
    rst_n = 1'b1;
    idle(2);
    xfer(0, 1'b0, 14'h41, 32'h0, 4'hF, 1, lat, rd);
    chk("after_rst_latency", 32'(lat), 32'd3);
    idle(3);

`ifdef RAM_WB_ARB_TIMEOUT_EN
    // 6: stalled slave -> single err pulse 8 cycles after grant
    ack_off = 1'b1;
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_we[0] = 1'b0; m_adr[0] = 14'h50;
    n = 0;
    do begin @(negedge clk); n++; end while (!m0_bus.err && n < 30);
    chk("tmo_err_cycle", 32'(n), 32'd10);
    chk("tmo_s_forced_low", 32'({s_bus.cyc, s_bus.stb}), 32'd0);
    @(posedge clk); #1;
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    @(negedge clk);
    chk("tmo_err_once", 32'(m0_bus.err), 32'd0);
    chk("tmo_gap_s_cyc", 32'(s_bus.cyc), 32'd0);
    ack_off = 1'b0;
    idle(3);
    xfer(0, 1'b0, 14'h50, 32'h0, 4'hF, 1, lat, rd);
    chk("tmo_rerequest_latency", 32'(lat), 32'd3);
    idle(2);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
